// File: rtl/ppu_pkg.sv
// Shared constants for the PPU CPU-side register file: register indices,
// ctrl/mask bit positions, VRAM address field slices and the render-time v increment.
package ppu_pkg;
    localparam logic [2:0] PPUCTRL   = 3'd0;
    localparam logic [2:0] PPUMASK   = 3'd1;
    localparam logic [2:0] PPUSTATUS = 3'd2;
    localparam logic [2:0] OAMADDR   = 3'd3;
    localparam logic [2:0] OAMDATA   = 3'd4;
    localparam logic [2:0] PPUSCROLL = 3'd5;
    localparam logic [2:0] PPUADDR   = 3'd6;
    localparam logic [2:0] PPUDATA   = 3'd7;

    localparam int CTRL_INC32    = 2;
    localparam int CTRL_NMI_EN   = 7;
    localparam int MASK_SHOW_BG  = 3;
    localparam int MASK_SHOW_SPR = 4;

    localparam int FINE_Y_MSB   = 14;
    localparam int FINE_Y_LSB   = 12;
    localparam int NT_SEL_MSB   = 11;
    localparam int NT_SEL_LSB   = 10;
    localparam int COARSE_Y_MSB = 9;
    localparam int COARSE_Y_LSB = 5;
    localparam int COARSE_X_MSB = 4;
    localparam int COARSE_X_LSB = 0;

    // Coarse X step plus Y step, as the renderer would do during a visible line.
    function automatic logic [14:0] render_inc(input logic [14:0] v);
        logic [14:0] r;
        r = v;
        if (r[COARSE_X_MSB:COARSE_X_LSB] == 5'd31) begin
            r[COARSE_X_MSB:COARSE_X_LSB] = 5'd0;
            r[NT_SEL_LSB] = ~r[NT_SEL_LSB];
        end else begin
            r[COARSE_X_MSB:COARSE_X_LSB] = r[COARSE_X_MSB:COARSE_X_LSB] + 5'd1;
        end
        if (r[FINE_Y_MSB:FINE_Y_LSB] != 3'd7) begin
            r[FINE_Y_MSB:FINE_Y_LSB] = r[FINE_Y_MSB:FINE_Y_LSB] + 3'd1;
        end else begin
            r[FINE_Y_MSB:FINE_Y_LSB] = 3'd0;
            if (r[COARSE_Y_MSB:COARSE_Y_LSB] == 5'd29) begin
                r[COARSE_Y_MSB:COARSE_Y_LSB] = 5'd0;
                r[NT_SEL_MSB] = ~r[NT_SEL_MSB];
            end else begin
                r[COARSE_Y_MSB:COARSE_Y_LSB] = r[COARSE_Y_MSB:COARSE_Y_LSB] + 5'd1;
            end
        end
        return r;
    endfunction
endpackage

// File: rtl/ppu_vblank_nmi.sv
// Vblank flag with status-read clear and same-cycle read suppression; drives the level NMI.
module ppu_vblank_nmi #(
    parameter int VBL_SET_LINE = 241,
    parameter int VBL_CLR_LINE = 261
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [8:0] x_i,
    input  logic [8:0] y_i,
    input  logic       status_rd_i,
    input  logic       nmi_en_i,
    output logic       vblank_rd_o,
    output logic       nmi_o
);
    logic vblank;
    logic set_cyc;
    logic clr_cyc;

    assign set_cyc = (x_i == 9'd1) && (y_i == 9'(VBL_SET_LINE));
    assign clr_cyc = (x_i == 9'd1) && (y_i == 9'(VBL_CLR_LINE));

    // A status read landing on the set cycle sees 0 and cancels this frame's set.
    assign vblank_rd_o = vblank & ~set_cyc;
    assign nmi_o       = vblank & nmi_en_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vblank <= 1'b0;
        end else if (clr_cyc) begin
            vblank <= 1'b0;
        end else if (set_cyc && !status_rd_i) begin
            vblank <= 1'b1;
        end else if (status_rd_i) begin
            vblank <= 1'b0;
        end
    end
endmodule

// File: rtl/ppu_cpu_regs.sv
// CPU-facing PPU registers $2000-$2007: builds t/fine X, owns w, issues v loads and $2007 accesses.
// Optional PPU_RENDER_GLITCH_INC_EN: $2007 during rendering steps v like the renderer instead of +1/+32.
module ppu_cpu_regs
    import ppu_pkg::*;
#(
    parameter int VBL_SET_LINE = 241,
    parameter int VBL_CLR_LINE = 261
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [2:0]  reg_sel_i,
    input  logic        reg_wr_i,
    input  logic        reg_rd_i,
    input  logic [7:0]  reg_wdata_i,
    output logic [7:0]  reg_rdata_o,
    input  logic [8:0]  x_i,
    input  logic [8:0]  y_i,
    input  logic [14:0] vram_addr_i,
    input  logic        sprite0_hit_i,
    input  logic        sprite_ovf_i,
    output logic [14:0] vram_home_addr_o,
    output logic [2:0]  fine_x_o,
    output logic        v_load_o,
    output logic [14:0] v_load_addr_o,
    output logic [7:0]  ctrl_o,
    output logic [7:0]  mask_o,
    output logic        rendering_enabled_o,
    output logic        vram_rd_o,
    output logic        vram_wr_o,
    output logic [13:0] vram_req_addr_o,
    output logic [7:0]  vram_wdata_o,
    input  logic        vram_rvalid_i,
    input  logic [7:0]  vram_rdata_i,
    output logic        nmi_o
);
    logic [14:0] t;
    logic        w;
    logic [7:0]  rbuf;
    logic        rd_en;
    logic        status_rd;
    logic        vblank_rd;
    logic [14:0] inc_addr;

    // Write wins when both strobes arrive together.
    assign rd_en     = reg_rd_i & ~reg_wr_i;
    assign status_rd = rd_en && (reg_sel_i == PPUSTATUS);

    assign vram_home_addr_o    = t;
    assign rendering_enabled_o = mask_o[MASK_SHOW_BG] | mask_o[MASK_SHOW_SPR];

`ifdef PPU_RENDER_GLITCH_INC_EN
    logic render_line;
    assign render_line = (y_i < 9'd240) || (y_i == 9'd261);
    assign inc_addr = (rendering_enabled_o && render_line) ? render_inc(vram_addr_i)
                    : vram_addr_i + (ctrl_o[CTRL_INC32] ? 15'd32 : 15'd1);
`else
    assign inc_addr = vram_addr_i + (ctrl_o[CTRL_INC32] ? 15'd32 : 15'd1);
`endif

    ppu_vblank_nmi #(
        .VBL_SET_LINE(VBL_SET_LINE),
        .VBL_CLR_LINE(VBL_CLR_LINE)
    ) u_vblank (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .x_i         (x_i),
        .y_i         (y_i),
        .status_rd_i (status_rd),
        .nmi_en_i    (ctrl_o[CTRL_NMI_EN]),
        .vblank_rd_o (vblank_rd),
        .nmi_o       (nmi_o)
    );

    always_comb begin
        reg_rdata_o = 8'd0;
        if (rd_en) begin
            case (reg_sel_i)
                PPUSTATUS: reg_rdata_o = {vblank_rd, sprite0_hit_i, sprite_ovf_i, 5'b0};
                PPUDATA:   reg_rdata_o = rbuf;
                PPUCTRL, PPUMASK, OAMADDR, OAMDATA, PPUSCROLL, PPUADDR: reg_rdata_o = 8'd0;
                default:   reg_rdata_o = 8'd0;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            t               <= '0;
            fine_x_o        <= '0;
            w               <= 1'b0;
            ctrl_o          <= '0;
            mask_o          <= '0;
            rbuf            <= '0;
            v_load_o        <= 1'b0;
            v_load_addr_o   <= '0;
            vram_rd_o       <= 1'b0;
            vram_wr_o       <= 1'b0;
            vram_req_addr_o <= '0;
            vram_wdata_o    <= '0;
        end else begin
            v_load_o  <= 1'b0;
            vram_rd_o <= 1'b0;
            vram_wr_o <= 1'b0;
            if (vram_rvalid_i) rbuf <= vram_rdata_i;
            if (reg_wr_i) begin
                case (reg_sel_i)
                    PPUCTRL: begin
                        ctrl_o  <= reg_wdata_i;
                        t[11:10] <= reg_wdata_i[1:0];
                    end
                    PPUMASK: mask_o <= reg_wdata_i;
                    PPUSCROLL: begin
                        if (!w) begin
                            t[4:0]   <= reg_wdata_i[7:3];
                            fine_x_o <= reg_wdata_i[2:0];
                        end else begin
                            t[14:12] <= reg_wdata_i[2:0];
                            t[9:5]   <= reg_wdata_i[7:3];
                        end
                        w <= ~w;
                    end
                    PPUADDR: begin
                        if (!w) begin
                            t[13:8] <= reg_wdata_i[5:0];
                            t[14]   <= 1'b0;
                        end else begin
                            t[7:0]        <= reg_wdata_i;
                            v_load_o      <= 1'b1;
                            v_load_addr_o <= {t[14:8], reg_wdata_i};
                        end
                        w <= ~w;
                    end
                    PPUDATA: begin
                        vram_wr_o       <= 1'b1;
                        vram_req_addr_o <= vram_addr_i[13:0];
                        vram_wdata_o    <= reg_wdata_i;
                        v_load_o        <= 1'b1;
                        v_load_addr_o   <= inc_addr;
                    end
                    default: ;
                endcase
            end else if (rd_en) begin
                case (reg_sel_i)
                    PPUSTATUS: w <= 1'b0;
                    PPUDATA: begin
                        vram_rd_o       <= 1'b1;
                        vram_req_addr_o <= vram_addr_i[13:0];
                        v_load_o        <= 1'b1;
                        v_load_addr_o   <= inc_addr;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: doc/ppu_cpu_regs.md
Name: ppu_cpu_regs

Overview:
- CPU-facing PPU register file ($2000-$2007 index 0-7). It is the writer side of the scroll/address protocol.
- Builds the home address t (15 bit) and fine X from CPU writes, and owns the shared write toggle w.
- Requests loads/increments of the live VRAM address v, issues $2007 VRAM accesses through a read buffer, and generates the vblank flag and NMI from the dot/scanline position.
- Sits between the CPU bus decoder and the PPU timing/address-increment logic.

Parameters:
VBL_SET_LINE, 241, scanline on which vblank is set (at dot 1)
VBL_CLR_LINE, 261, scanline on which vblank/status flags clear (at dot 1)

Ports:
clk_i  in  1  PPU clock
rst_i  in  1  asynchronous active-high reset
reg_sel_i  in  3  CPU register index (0-7)
reg_wr_i  in  1  one-cycle CPU write strobe
reg_rd_i  in  1  one-cycle CPU read strobe
reg_wdata_i  in  8  CPU write data
reg_rdata_o  out  8  CPU read data, combinational, valid in the strobe cycle
x_i  in  9  current dot (0-340)
y_i  in  9  current scanline (0-261)
vram_addr_i  in  15  live v register
sprite0_hit_i  in  1  status bit 6 source
sprite_ovf_i  in  1  status bit 5 source
vram_home_addr_o  out  15  t register
fine_x_o  out  3  fine X scroll
v_load_o  out  1  one-cycle pulse: replace v with v_load_addr_o (overrides renderer update)
v_load_addr_o  out  15  value to load into v
ctrl_o  out  8  $2000 contents
mask_o  out  8  $2001 contents
rendering_enabled_o  out  1  mask_o[3] | mask_o[4]
vram_rd_o  out  1  one-cycle VRAM read request
vram_wr_o  out  1  one-cycle VRAM write request
vram_req_addr_o  out  14  request address (v[13:0] at strobe)
vram_wdata_o  out  8  write data
vram_rvalid_i  in  1  read data valid
vram_rdata_i  in  8  read data
nmi_o  out  1  level NMI, = vblank & ctrl_o[7]

Behaviour:
- Reset: all outputs, t, fine X, w, ctrl, mask, vblank and read buffer are 0; no pulses.
- Write idx0: ctrl <= d; t[11:10] <= d[1:0].
- Write idx1: mask <= d.
- Write idx5, w=0: t[4:0] <= d[7:3]; fine_x <= d[2:0]; w <= 1.
- Write idx5, w=1: t[14:12] <= d[2:0]; t[9:5] <= d[7:3]; w <= 0.
- Write idx6, w=0: t[13:8] <= d[5:0]; t[14] <= 0; w <= 1.
- Write idx6, w=1: t[7:0] <= d; w <= 0. Next cycle: v_load_o=1 and v_load_addr_o = new t.
- Read idx2: rdata = {vblank, sprite0_hit_i, sprite_ovf_i, 5'b0}. Then vblank <= 0 and w <= 0.
- Vblank set: at x_i=1, y_i=VBL_SET_LINE.
  - If an idx2 read coincides with the set cycle, it returns bit7=0 and the set is suppressed for this frame.
- Vblank clear: at x_i=1, y_i=VBL_CLR_LINE. Clear takes priority over everything.
- nmi_o is combinational.
  - Setting ctrl[7] while vblank=1 raises nmi_o immediately.
  - Clearing vblank drops nmi_o.
- $2007 (idx7) write at cycle N:
  - N+1: vram_wr_o=1, addr = v[13:0] sampled at N, wdata=d.
  - N+1: v_load_o=1, v_load_addr_o = (v + inc) mod 2^15, with inc = ctrl[2] ? 32 : 1.
- $2007 read at cycle N:
  - rdata = read buffer (prior value).
  - N+1: vram_rd_o pulse plus the same v increment.
  - The buffer updates on each vram_rvalid_i. A new read while one is pending is still issued; the last rvalid wins.
- Reads of write-only indices return 0. Writes to read-only indices are ignored. Reads of 0, 1, 3, 4, 5, 6 have no side effects.
- Simultaneous read and write strobes: the write wins, the read is ignored.
- Reset asserted mid-operation: any pending request is dropped; no pulse follows.

Optional Feature:
Macro PPU_RENDER_GLITCH_INC_EN.
- Defined: a $2007 access while rendering_enabled_o=1 and (y_i<240 or y_i=261) does not add 1/32. Instead v_load_addr_o = v with coarse X incremented (nametable bit 10 flips on wrap 31) and Y incremented (fine Y, then coarse Y; 29 wraps to 0 with bit 11 flipped).
- Undefined: the increment is always 1/32.

Decomposition:
- Package ppu_pkg holds:
  - register index constants PPUCTRL..PPUDATA;
  - ctrl/mask bit positions;
  - VRAM address field slices (fine_y, nt_sel, coarse_y, coarse_x).
- One natural sub-module, ppu_vblank_nmi, owns the vblank flag, read suppression and nmi_o.

Test Plan:
- idx5 0x7D then 0x5E -> t[4:0]=15, fine_x=5, t[14:12]=6, t[9:5]=11, w back to 0.
- idx6 0x21 then 0x08 -> t=0x2108; next cycle v_load_o=1, v_load_addr_o=0x2108; a single-cycle pulse.
- ctrl[2]=1, v=0x23C0, idx7 write 0xAA -> vram_wr_o with addr 0x23C0, data 0xAA; v_load_addr_o=0x23E0.
- idx7 read twice, VRAM returns 0x11 then 0x22 -> CPU gets the stale buffer, then 0x11.
- Run to y=241 x=1 with ctrl[7]=1 -> nmi_o rises; idx2 read returns 0x80 and nmi_o falls; a read exactly at the set cycle returns 0x00 and no NMI occurs.
- idx6 first write, then idx2 read, then idx6 0x3F -> treated as the first write again: t[13:8]=0x3F, no v_load.
